// File: rtl/gray_pkg.sv
// gray_pkg -- shared constants and types for the Gray sequence generator.
//   GRAY_WIDTH : default code-word / beat-count width
//   state_t    : FSM states IDLE, RUN, DONE
package gray_pkg;
  localparam int GRAY_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;
endpackage

// File: rtl/gray_seq_gen_bin2gray.sv
// bin2gray -- combinational binary-to-Gray converter.
//   bin  : binary input word
//   gray : Gray-coded word, g = b ^ (b >> 1)
module bin2gray #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] bin,
  output logic [WIDTH-1:0] gray
);
  assign gray = bin ^ (bin >> 1);
endmodule

// File: rtl/gray_seq_gen.sv
// gray_seq_gen -- emits a run of len+1 Gray-coded words, counting up or down
// from seed, over a valid/ready handshake.
//   clk, rst        : clock, asynchronous active-high reset
//   start           : launch a sequence (accepted in IDLE only)
//   seed, len, dir  : start value, beats-1, 1=up/0=down (captured on start)
//   abort           : drop the active sequence, no done pulse
//   gray, valid     : registered output word and its qualifier
//   ready           : downstream accept
//   busy            : high while in RUN
//   done            : one-cycle pulse after the final transfer
module gray_seq_gen
  import gray_pkg::*;
#(
  parameter int WIDTH = GRAY_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] seed,
  input  logic [WIDTH-1:0] len,
  input  logic             dir,
  input  logic             abort,
  output logic [WIDTH-1:0] gray,
  output logic             valid,
  input  logic             ready,
  output logic             busy,
  output logic             done
);
  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  state_t           state_q, state_d;
  logic [WIDTH-1:0] bin_q, bin_d;
  logic [WIDTH-1:0] gray_q, gray_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             dir_q, dir_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  // gray is always re-derived from the next binary value, so holding bin
  // also holds gray and the two can never drift apart.
  bin2gray #(.WIDTH(WIDTH)) u_bin2gray (
    .bin  (bin_d),
    .gray (gray_d)
  );

  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    rem_d   = rem_q;
    dir_d   = dir_q;
    valid_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          bin_d   = seed;
          rem_d   = len;
          dir_d   = dir;
          valid_d = 1'b1;
        end
      end
      RUN: begin
        valid_d = 1'b1;
        if (abort) begin
          // abort wins over a same-edge transfer; the word is left as is
          state_d = IDLE;
          valid_d = 1'b0;
        end else if (valid_q && ready) begin
          if (rem_q == '0) begin
            state_d = DONE;
            valid_d = 1'b0;
          end else begin
            bin_d = dir_q ? bin_q + ONE : bin_q - ONE;
            rem_d = rem_q - ONE;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      bin_q   <= '0;
      gray_q  <= '0;
      rem_q   <= '0;
      dir_q   <= 1'b1;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      gray_q  <= gray_d;
      rem_q   <= rem_d;
      dir_q   <= dir_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign gray  = gray_q;
  assign valid = valid_q;
  assign busy  = busy_q;
  assign done  = done_q;
endmodule

// File: tb/tb_gray_seq_gen.sv
// tb_gray_seq_gen -- directed and randomized checks of gray_seq_gen against a
// counting model (expected binary = seed +/- beat index, mod 2^W).
module tb_gray_seq_gen;
  localparam int W    = 4;
  localparam int MODV = 1 << W;

  logic         clk, rst, start, dir, abort, ready;
  logic [W-1:0] seed, len;
  logic [W-1:0] gray;
  logic         valid, busy, done;

  int errors = 0;
  int checks = 0;

  gray_seq_gen #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .seed  (seed),
    .len   (len),
    .dir   (dir),
    .abort (abort),
    .gray  (gray),
    .valid (valid),
    .ready (ready),
    .busy  (busy),
    .done  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Gray -> binary: each binary bit is the XOR of all Gray bits at or above it.
  function automatic int g2b(input logic [W-1:0] g);
    int b = 0;
    for (int i = 0; i < W; i++) b |= (int'(^(g >> i)) << i);
    return b;
  endfunction

  function automatic int exp_bin(input int s, input int d, input int i);
    return d ? (s + i) % MODV : (s - i + MODV * 16) % MODV;
  endfunction

  function automatic int to_gray(input int b);
    return b ^ (b >> 1);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Run one full sequence; ready is low for stall_first cycles on word 0,
  // then either always high or random. spam drives stray start pulses
  // during RUN and DONE.
  task automatic run_seq(input int s, input int l, input int d,
                         input int stall_first, input bit rnd_ready,
                         input bit spam);
    int idx = 0, stalls = 0, budget = 0, prev = -1;
    seed = W'(s); len = W'(l); dir = d[0]; start = 1'b1;
    tick();
    start = 1'b0;
    chk("start_busy", int'(busy), 1);
    while (idx <= l) begin
      if (budget++ > 400) begin
        chk("seq_timeout", idx, l + 1);
        break;
      end
      chk("run_valid", int'(valid), 1);
      chk("run_done", int'(done), 0);
      chk("gray_word", int'(gray), to_gray(exp_bin(s, d, idx)));
      chk("inv_bin", g2b(gray), exp_bin(s, d, idx));
      if (prev >= 0 && prev != int'(gray))
        chk("one_bit", $countones(W'(prev) ^ gray), 1);
      prev = int'(gray);
      if (idx == 0 && stalls < stall_first) begin
        ready = 1'b0;
        stalls++;
      end else begin
        ready = rnd_ready ? ($urandom_range(0, 9) < 7) : 1'b1;
      end
      start = spam ? 1'($urandom_range(0, 1)) : 1'b0;
      tick();
      if (ready) idx++;
    end
    ready = 1'b0;
    chk("done_pulse", int'(done), 1);
    chk("done_valid", int'(valid), 0);
    chk("done_busy", int'(busy), 0);
    chk("done_gray", int'(gray), to_gray(exp_bin(s, d, l)));
    start = spam;
    tick();
    start = 1'b0;
    chk("idle_done", int'(done), 0);
    chk("idle_valid", int'(valid), 0);
    tick();
    chk("idle_noqueue_valid", int'(valid), 0);
    chk("idle_noqueue_busy", int'(busy), 0);
    chk("idle_hold_gray", int'(gray), to_gray(exp_bin(s, d, l)));
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; dir = 1'b0; abort = 1'b0; ready = 1'b0;
    seed = '0; len = '0;
    #2;
    chk("rst_gray", int'(gray), 0);
    chk("rst_valid", int'(valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    #10 rst = 1'b0;
    tick();
    chk("idle_valid0", int'(valid), 0);

    // Basic up count, up wrap, down wrap, stalled first word
    run_seq(3, 3, 1, 0, 1'b0, 1'b0);
    run_seq(14, 3, 1, 0, 1'b0, 1'b0);
    run_seq(1, 2, 0, 0, 1'b0, 1'b0);
    run_seq(0, 2, 1, 3, 1'b0, 1'b0);

    // Abort on the 2nd transfer edge of a 6-beat sequence
    seed = 4'd5; len = 4'd5; dir = 1'b1; start = 1'b1;
    tick();
    start = 1'b0; ready = 1'b1;
    chk("ab_w0", int'(gray), to_gray(5));
    tick();
    chk("ab_w1", int'(gray), to_gray(6));
    abort = 1'b1;
    tick();
    abort = 1'b0; ready = 1'b0;
    chk("ab_valid", int'(valid), 0);
    chk("ab_busy", int'(busy), 0);
    chk("ab_done", int'(done), 0);
    tick();
    chk("ab_nodone", int'(done), 0);
    abort = 1'b1;   // abort outside RUN is harmless
    tick();
    abort = 1'b0;
    run_seq(9, 1, 0, 0, 1'b0, 1'b0);

    // Asynchronous reset mid-RUN, between clock edges
    seed = 4'd7; len = 4'd6; dir = 1'b1; start = 1'b1;
    tick();
    start = 1'b0; ready = 1'b1;
    tick();
    tick();
    chk("pre_rst_valid", int'(valid), 1);
    #2 rst = 1'b1;
    #1;
    chk("arst_gray", int'(gray), 0);
    chk("arst_valid", int'(valid), 0);
    chk("arst_busy", int'(busy), 0);
    chk("arst_done", int'(done), 0);
    #2 rst = 1'b0; ready = 1'b0;
    tick();
    tick();
    chk("post_rst_valid", int'(valid), 0);
    chk("post_rst_busy", int'(busy), 0);

    // Full 16-beat walk, plus start spam in RUN/DONE
    run_seq(0, 15, 1, 0, 1'b0, 1'b0);
    run_seq(11, 4, 0, 0, 1'b1, 1'b1);

    // Randomized sequences with random back-pressure
    for (int n = 0; n < 8; n++)
      run_seq($urandom_range(0, MODV - 1), $urandom_range(0, MODV - 1),
              $urandom_range(0, 1), $urandom_range(0, 2), 1'b1, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
